// File: rtl/fir_coeff_loader_if.sv
// Byte-stream input and coefficient-write output bundle of the FIR coefficient loader.
// slave: the loader itself; master: the host/config side that feeds taps and watches the writes.
interface fir_coeff_loader_if #(
  parameter int COEF_WIDTH = 8,
  parameter int IDX_WIDTH  = 4
);
  logic                         s_valid;
  logic                         s_ready;
  logic signed [COEF_WIDTH-1:0] s_data;
  logic [IDX_WIDTH-1:0]         coefficient_number;
  logic signed [COEF_WIDTH-1:0] coefficient_value;
  logic                         coefficient_write_enable;
  logic                         busy;
  logic                         done;
  logic                         error;

  modport slave (
    input  s_valid, s_data,
    output s_ready, coefficient_number, coefficient_value,
           coefficient_write_enable, busy, done, error
  );

  modport master (
    output s_valid, s_data,
    input  s_ready, coefficient_number, coefficient_value,
           coefficient_write_enable, busy, done, error
  );
endinterface

// File: rtl/fir_coeff_loader.sv
// Buffers one complete signed tap set from a valid/ready byte stream, then replays it as
// coefficient writes. Optional trailing checksum byte when COEF_LOADER_CHECKSUM_EN is defined.
module fir_coeff_loader #(
  parameter int NUM_TAPS    = 10,
  parameter int COEF_WIDTH  = 8,
  parameter int IDX_WIDTH   = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  fir_coeff_loader_if.slave bus
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_TAP  = IDX_WIDTH'(NUM_TAPS - 1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CHECK   = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                       state_q, state_nxt;
  logic [IDX_WIDTH-1:0]         cnt_q, cnt_nxt;
  logic [HOLD_W-1:0]            hold_q, hold_nxt;
  logic [IDX_WIDTH-1:0]         num_q, num_nxt;
  logic signed [COEF_WIDTH-1:0] val_q, val_nxt;
  logic                         rdy_q, rdy_nxt;
  logic                         we_q, we_nxt;
  logic                         busy_q, busy_nxt;
  logic                         done_q, done_nxt;
  logic                         accept, buf_we, start_wr;
  logic signed [COEF_WIDTH-1:0] tap_buf [NUM_TAPS];

`ifdef COEF_LOADER_CHECKSUM_EN
  logic err_q, err_nxt;

  // Plain modulo-2**COEF_WIDTH sum of the stored tap bit patterns.
  function automatic logic [COEF_WIDTH-1:0] tap_sum();
    logic [COEF_WIDTH-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_TAPS; i++) s = s + $unsigned(tap_buf[i]);
    return s;
  endfunction
`endif

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    hold_nxt  = hold_q;
    num_nxt   = num_q;
    val_nxt   = val_q;
    rdy_nxt   = 1'b0;
    we_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    buf_we    = 1'b0;
    start_wr  = 1'b0;
    accept    = bus.s_valid && rdy_q;
`ifdef COEF_LOADER_CHECKSUM_EN
    err_nxt   = 1'b0;
`endif
    case (state_q)
      COLLECT: begin
        rdy_nxt = 1'b1;
        if (accept) begin
          buf_we = 1'b1;
          if (cnt_q == LAST_TAP) begin
            cnt_nxt = '0;
`ifdef COEF_LOADER_CHECKSUM_EN
            state_nxt = CHECK;
`else
            start_wr = 1'b1;
`endif
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
      end
`ifdef COEF_LOADER_CHECKSUM_EN
      CHECK: begin
        rdy_nxt = 1'b1;
        if (accept) begin
          if ($unsigned(bus.s_data) == tap_sum()) begin
            start_wr = 1'b1;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = COLLECT;
          end
        end
      end
`endif
      WRITE: begin
        we_nxt   = 1'b1;
        busy_nxt = 1'b1;
        if (hold_q == HOLD_LAST) begin
          hold_nxt = '0;
          if (num_q == LAST_TAP) begin
            state_nxt = DONE;
            we_nxt    = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            num_nxt = num_q + 1'b1;
            val_nxt = tap_buf[num_nxt];
          end
        end else begin
          hold_nxt = hold_q + 1'b1;
        end
      end
      DONE: begin
        state_nxt = COLLECT;
        rdy_nxt   = 1'b1;
      end
      default: state_nxt = COLLECT;
    endcase

    // Tap 0 goes out on the edge that completes the set; with a single tap it is still in flight.
    if (start_wr) begin
      state_nxt = WRITE;
      rdy_nxt   = 1'b0;
      we_nxt    = 1'b1;
      busy_nxt  = 1'b1;
      num_nxt   = '0;
      hold_nxt  = '0;
      val_nxt   = (NUM_TAPS == 1 && buf_we) ? bus.s_data : tap_buf[0];
    end
  end

  // ---- registered control and outputs ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      hold_q  <= '0;
      num_q   <= '0;
      val_q   <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      hold_q  <= hold_nxt;
      num_q   <= num_nxt;
      val_q   <= val_nxt;
      rdy_q   <= rdy_nxt;
      we_q    <= we_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  // ---- tap buffer ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TAPS; i++) tap_buf[i] <= '0;
    end else if (buf_we) begin
      tap_buf[cnt_q] <= bus.s_data;
    end
  end

`ifdef COEF_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_nxt;
  end
  assign bus.error = err_q;
`else
  assign bus.error = 1'b0;
`endif

  assign bus.s_ready                  = rdy_q;
  assign bus.coefficient_number       = num_q;
  assign bus.coefficient_value        = val_q;
  assign bus.coefficient_write_enable = we_q;
  assign bus.busy                     = busy_q;
  assign bus.done                     = done_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader: one instance with HOLD_CYCLES=1, one with HOLD_CYCLES=5.
// Expected writes are queued when a tap set is issued; a negedge monitor pops and compares.
module tb_fir_coeff_loader;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_coeff_loader_if #(.COEF_WIDTH(8), .IDX_WIDTH(4)) b0 ();
  fir_coeff_loader_if #(.COEF_WIDTH(8), .IDX_WIDTH(4)) b1 ();

  fir_coeff_loader #(.NUM_TAPS(10), .COEF_WIDTH(8), .IDX_WIDTH(4), .HOLD_CYCLES(1)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  fir_coeff_loader #(.NUM_TAPS(10), .COEF_WIDTH(8), .IDX_WIDTH(4), .HOLD_CYCLES(5)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  typedef struct {
    logic [3:0] num;
    logic [7:0] val;
    bit         first;
    bit         last;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         last_acc [2];
  int         prev_cyc [2];
  int         done_due [2];
  int         done_seen[2];
  int         exp_done [2];
  int         err_seen = 0;
  int         exp_err = 0;
  logic [7:0] set_buf [10];

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic mon(input int id, input logic vld, input logic rdy, input logic we,
                     input logic [3:0] num, input logic [7:0] val, input logic busy,
                     input logic done, input logic err);
    exp_t e;
    bit   have;
    if (vld && rdy) last_acc[id] = cyc + 1;
    if (we) begin
      have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!have) begin
        n_chk++;
        $display("FAIL unexpected_strobe dut%0d: strobe number %0d value 0x%02h, required no strobe",
                 id, num, val);
      end else begin
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        chk($sformatf("write_dut%0d_num_val_busy_rdy", id), {num, val, busy, rdy},
            {e.num, e.val, 1'b1, 1'b0});
        chk($sformatf("strobe_cycle_dut%0d_tap%0d", id, e.num), cyc,
            e.first ? last_acc[id] : prev_cyc[id] + 1);
        prev_cyc[id] = cyc;
        if (e.last) done_due[id] = cyc + 1;
      end
    end
    if (done) begin
      chk($sformatf("done_cycle_dut%0d", id), cyc, done_due[id]);
      chk($sformatf("done_we_busy_dut%0d", id), {we, busy}, 2'b00);
      done_due[id] = -1;
      done_seen[id]++;
    end
    if (err) begin
      err_seen++;
      chk($sformatf("error_cycle_dut%0d", id), cyc, last_acc[id]);
    end
  endtask

  always @(negedge clk) begin
    mon(0, b0.s_valid, b0.s_ready, b0.coefficient_write_enable, b0.coefficient_number,
        b0.coefficient_value, b0.busy, b0.done, b0.error);
    mon(1, b1.s_valid, b1.s_ready, b1.coefficient_write_enable, b1.coefficient_number,
        b1.coefficient_value, b1.busy, b1.done, b1.error);
  end

  task automatic drive(input int id, input logic v, input logic [7:0] d);
    if (id == 0) begin b0.s_valid = v; b0.s_data = d; end
    else         begin b1.s_valid = v; b1.s_data = d; end
  endtask

  task automatic send_byte(input int id, input logic [7:0] b, input int gap);
    int   n;
    logic rdy;
    n = 0;
    drive(id, 1'b1, b);
    do begin
      @(negedge clk);
      rdy = (id == 0) ? b0.s_ready : b1.s_ready;
      n++;
    end while (!rdy && n < 300);
    if (!rdy) begin
      n_chk++;
      $display("FAIL handshake_timeout dut%0d: s_ready 0 for %0d cycles, required 1", id, n);
    end
    @(posedge clk); #1;
    if (gap > 0) begin
      drive(id, 1'b0, 8'h00);
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  // Issues set_buf (plus checksum byte when enabled); queues the writes it should produce.
  task automatic send_set(input int id, input int maxgap, input bit good);
    exp_t e;
    int   hold;
    hold = (id == 0) ? 1 : 5;
    if (good) begin
      for (int k = 0; k < 10; k++) begin
        for (int h = 0; h < hold; h++) begin
          e.num   = 4'(k);
          e.val   = set_buf[k];
          e.first = (k == 0 && h == 0);
          e.last  = (k == 9 && h == hold - 1);
          if (id == 0) q0.push_back(e);
          else         q1.push_back(e);
        end
      end
      exp_done[id]++;
    end
    for (int k = 0; k < 10; k++)
      send_byte(id, set_buf[k], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
`ifdef COEF_LOADER_CHECKSUM_EN
    begin
      logic [7:0] ck;
      ck = 8'h00;
      for (int k = 0; k < 10; k++) ck = ck + set_buf[k];
      if (!good) begin
        ck = ck - 8'h01;
        exp_err++;
      end
      send_byte(id, ck, 0);
    end
`endif
    drive(id, 1'b0, 8'h00);
  endtask

  task automatic wait_idle(input int id);
    int n;
    n = 0;
    while ((((id == 0) ? q0.size() : q1.size()) != 0 || done_due[id] >= 0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      n_chk++;
      $display("FAIL write_timeout dut%0d: %0d writes still pending, required 0", id,
               (id == 0) ? q0.size() : q1.size());
    end else begin
      chk($sformatf("ready_after_done_dut%0d", id), (id == 0) ? b0.s_ready : b1.s_ready, 1);
    end
  endtask

  initial begin
    bit found;
    last_acc  = '{0, 0};
    prev_cyc  = '{0, 0};
    done_due  = '{-1, -1};
    done_seen = '{0, 0};
    exp_done  = '{0, 0};

    // 1: reset state and s_ready rising one edge after release
    reset = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (5) @(posedge clk);
    #1;
    chk("reset_outputs_dut0", {b0.s_ready, b0.coefficient_write_enable, b0.busy, b0.done,
        b0.error, b0.coefficient_number, b0.coefficient_value}, 0);
    chk("reset_outputs_dut1", {b1.s_ready, b1.coefficient_write_enable, b1.busy, b1.done,
        b1.error, b1.coefficient_number, b1.coefficient_value}, 0);
    reset = 1'b1;
    chk("ready_before_first_edge", b0.s_ready, 0);
    @(posedge clk); #1;
    chk("ready_busy_after_release", {b0.s_ready, b0.busy}, 2'b10);

    // 2: taps 1..10 back-to-back
    set_buf = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    send_set(0, 0, 1'b1);
    wait_idle(0);

    // 3: random gaps, next set presented while the previous one is being written
    set_buf = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    send_set(0, 2, 1'b1);
    set_buf = '{8'hF0, 8'h0F, 8'h80, 8'h7F, 8'h01, 8'hFF, 8'hC3, 8'h3C, 8'h5A, 8'hA5};
    send_set(0, 3, 1'b1);
    wait_idle(0);

    // 4: reset in the middle of the tap-4 strobe, then a fresh set
    set_buf = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29, 8'h2A};
    send_set(0, 0, 1'b1);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (b0.coefficient_write_enable && b0.coefficient_number == 4'd4) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!found) begin
      n_chk++;
      $display("FAIL tap4_strobe_timeout: strobe for tap 4 not seen, required within 100 cycles");
    end
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset_drop", {b0.coefficient_write_enable, b0.busy, b0.s_ready, b0.done}, 0);
    q0.delete();
    done_due[0] = -1;
    exp_done[0]--;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    set_buf = '{8'h31, 8'hC2, 8'h33, 8'hC4, 8'h35, 8'hC6, 8'h37, 8'hC8, 8'h39, 8'hCA};
    send_set(0, 1, 1'b1);
    wait_idle(0);

    // 5: HOLD_CYCLES=5 instance, extreme signed values
    set_buf = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'hFE, 8'h40, 8'hBF, 8'h02, 8'hFD};
    send_set(1, 0, 1'b1);
    wait_idle(1);

`ifdef COEF_LOADER_CHECKSUM_EN
    // 6: good checksum (55) then bad checksum (54)
    set_buf = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    send_set(0, 0, 1'b1);
    wait_idle(0);
    send_set(0, 0, 1'b0);
    chk("checksum_bad_err_we_rdy", {b0.error, b0.coefficient_write_enable, b0.s_ready}, 3'b101);
    repeat (3) @(posedge clk);
    #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("pending_writes_dut0", q0.size(), 0);
    chk("pending_writes_dut1", q1.size(), 0);
    chk("done_count_dut0", done_seen[0], exp_done[0]);
    chk("done_count_dut1", done_seen[1], exp_done[1]);
    chk("error_count", err_seen, exp_err);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
